// File: rtl/sap1_program_loader.sv
// SAP-1 program loader: fills the 16x8 program RAM from a valid/ready byte stream and holds
// the CPU in reset until the image is complete. Optional macro: SAP1_LOADER_CHECKSUM_EN.
module sap1_program_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RUN_DELAY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_byte_cnt
);

  localparam int PROG_LEN = 1 << ADDR_W;
`ifdef SAP1_LOADER_CHECKSUM_EN
  localparam int LOAD_LEN = PROG_LEN + 1;
`else
  localparam int LOAD_LEN = PROG_LEN;
`endif
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_LEN - 1);
  localparam logic [ADDR_W:0] PROG_CNT = (ADDR_W+1)'(PROG_LEN);
  localparam int SW = (RUN_DELAY > 0) ? $clog2(RUN_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN
`ifdef SAP1_LOADER_CHECKSUM_EN
    , S_CHECK,
    S_ERR
`endif
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_byte_cnt;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [SW-1:0]     r_settle;
  logic              w_xfer;
  logic              w_start_load;
`ifdef SAP1_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  always_comb begin
    w_next     = r_state;
    w_xfer     = 1'b0;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_cpu_rst  = 1'b1;
    o_done     = 1'b0;
    o_load_err = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_in_valid) begin
          w_xfer = 1'b1;
`ifdef SAP1_LOADER_CHECKSUM_EN
          if (r_byte_cnt == LAST_IDX) w_next = S_CHECK;
`else
          if (r_byte_cnt == LAST_IDX) w_next = S_SETTLE;
`endif
        end
      end
`ifdef SAP1_LOADER_CHECKSUM_EN
      S_CHECK: begin
        o_busy = 1'b1;
        w_next = (r_sum == '0) ? S_SETTLE : S_ERR;
      end
      S_ERR: begin
        o_load_err = 1'b1;
        if (i_start) w_next = S_LOAD;
      end
`endif
      S_SETTLE: begin
        o_busy = 1'b1;
        if (r_settle == SW'(RUN_DELAY)) w_next = S_RUN;
      end
      S_RUN: begin
        o_cpu_rst = 1'b0;
        o_done    = 1'b1;
        if (i_start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Entering LOAD from any idle-type state restarts the byte count (and checksum).
  assign w_start_load = (r_state != S_LOAD) && (w_next == S_LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_settle    <= '0;
`ifdef SAP1_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state  <= w_next;
      r_ram_we <= 1'b0;
      r_settle <= (r_state == S_SETTLE) ? r_settle + 1'b1 : '0;
      if (w_start_load) begin
        r_byte_cnt <= '0;
`ifdef SAP1_LOADER_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end
      if (w_xfer) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef SAP1_LOADER_CHECKSUM_EN
        r_sum      <= r_sum + i_in_data;
`endif
        // The trailing checksum byte is counted but never written.
        if (r_byte_cnt < PROG_CNT) begin
          r_ram_we    <= 1'b1;
          r_ram_addr  <= r_byte_cnt[ADDR_W-1:0];
          r_ram_wdata <= i_in_data;
        end
      end
    end
  end

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Scoreboard bench for sap1_program_loader: random-stream loads checked against a RAM image model.
module tb_sap1_program_loader;
  localparam int ADDR_W = 4, DATA_W = 8, RUN_DELAY = 2;
  localparam int PROG = 16;
`ifdef SAP1_LOADER_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif
  localparam int LOAD_LEN = PROG + CKS;

  logic       clk = 0, rst_n = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = '0;
  logic       in_ready, ram_we, cpu_rst, busy, done, load_err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [4:0] byte_cnt;

  int  errors = 0, checks = 0, cyc = 0, run_at = -1, wr_cnt = 0;
  bit  exp_run = 0;
  logic [7:0]  img   [PROG];
  logic [7:0]  tb_ram[PROG];
  logic [7:0]  strm  [PROG+1];
  logic [11:0] sb[$];
  logic [11:0] mon_e;

  sap1_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_DELAY(RUN_DELAY)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_data(in_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_cpu_rst(cpu_rst),
    .o_busy(busy), .o_done(done), .o_load_err(load_err), .o_byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && ram_we) tb_ram[ram_addr] <= ram_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM strobe must match the next expected (addr,data); CPU reset/done follow model.
  always @(negedge clk) if (rst_n) begin
    if (ram_we) begin
      if (sb.size() == 0) chk("spurious_we", ram_we, 0);
      else begin
        mon_e = sb.pop_front();
        chk("ram_addr", ram_addr, mon_e[11:8]);
        chk("ram_wdata", ram_wdata, mon_e[7:0]);
      end
      wr_cnt++;
`ifndef SAP1_LOADER_CHECKSUM_EN
      if (wr_cnt == PROG) chk("ready_at_last_we", in_ready, 0);
`endif
    end
    if (cyc == run_at) exp_run = 1;
    chk("cpu_rst", cpu_rst, !exp_run);
    chk("done", done, exp_run);
  end

  // vmode: 0 valid always, 1 toggling, 2 random. start_at/rst_at: byte index for disturbance.
  task automatic do_load(input int vmode, input int start_at, input int rst_at, input bit bad);
    int idx = 0, guard = 0;
    bit acc;
    logic [7:0] sum = '0;
    for (int i = 0; i < PROG; i++) begin strm[i] = img[i]; sum += img[i]; end
    strm[PROG] = 8'h00 - sum + {7'd0, bad};
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    exp_run = 0; run_at = -1; wr_cnt = 0;
    chk("start_clr_err", load_err, 0);
    chk("start_cnt", byte_cnt, 0);
    chk("start_busy", busy, 1);
    while (idx < LOAD_LEN && guard < 400) begin
      guard++;
      if (idx == rst_at) begin
        rst_n = 0; in_valid = 0; #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", byte_cnt, 0);
        sb.delete(); wr_cnt = 0; exp_run = 0; run_at = -1;
        @(posedge clk); #2 rst_n = 1;
        return;
      end
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~in_valid;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? strm[idx] : 8'($urandom);
      if (idx == start_at && in_valid) start = 1;
      acc = in_valid && in_ready;
      @(posedge clk); #1 start = 0;
      if (acc) begin
        if (idx < PROG) sb.push_back({idx[3:0], strm[idx]});
        idx++;
        if (idx == LOAD_LEN && !bad) run_at = cyc + RUN_DELAY + 1 + CKS;
      end
    end
    in_valid = 0;
    if (idx < LOAD_LEN) chk("load_timeout", idx, LOAD_LEN);
  endtask

  task automatic finish_load(input bit bad);
    repeat (RUN_DELAY + 6) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("final_done", done, !bad);
    chk("final_cpu_rst", cpu_rst, bad);
    chk("final_busy", busy, 0);
    chk("final_err", load_err, bad);
    chk("final_cnt", byte_cnt, LOAD_LEN);
    for (int a = 0; a < PROG; a++) chk("ram_image", tb_ram[a], img[a]);
  endtask

  task automatic rand_img();
    for (int i = 0; i < PROG; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] prog0 [PROG] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h10, 8'h14, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    #2 rst_n = 0;
    #1;
    chk("por_cpu_rst", cpu_rst, 1);
    chk("por_in_ready", in_ready, 0);
    chk("por_we", ram_we, 0);
    chk("por_done", done, 0);
    chk("por_busy", busy, 0);
    chk("por_err", load_err, 0);
    chk("por_cnt", byte_cnt, 0);
    chk("por_addr", ram_addr, 0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);

    img = prog0;
    do_load(0, -1, -1, 0); finish_load(0);
    rand_img(); do_load(1, -1, -1, 0); finish_load(0);
    rand_img(); do_load(2, 7, -1, 0);  finish_load(0);
    rand_img(); do_load(0, -1, 9, 0);
    rand_img(); do_load(2, -1, -1, 0); finish_load(0);
`ifdef SAP1_LOADER_CHECKSUM_EN
    img = prog0;
    do_load(0, -1, -1, 1); finish_load(1);
    do_load(0, -1, -1, 0); finish_load(0);
`endif
    for (int k = 0; k < 3; k++) begin
      rand_img(); do_load(2, $urandom_range(0, 15), -1, 0); finish_load(0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end
endmodule
